rce_bus_master: RTL and testbench



---
 rtl/rce_bus_master.sv | 219 +++++++++++++++++++++
 tb/tb_rce_bus_master.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rce_bus_master.sv
// rce_bus_master: single-command initiator for the RAVAN engine register port.
// Drives the AW/W/B and AR/R channels for one command at a time and returns
// one response per command. A per-transaction timeout keeps a hung engine
// from stalling the requester.
module rce_bus_master #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              awvalid,
  output logic              wvalid,
  output logic              arvalid,
  output logic              bready,
  output logic              rready,
  input  logic              awready,
  input  logic              wready,
  input  logic              arready,
  input  logic              bvalid,
  input  logic              rvalid,
  input  logic [DATA_W-1:0] data_out,
  input  logic              sha_error_out
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    RESP
  } state_t;

  // The counter only has to reach TIMEOUT_CYCLES-1; the expiry cycle is the
  // one in which the count would reach TIMEOUT_CYCLES.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               expire;

  logic               awvalid_d, wvalid_d, arvalid_d, bready_d, rready_d;
  logic [ADDR_W-1:0]  address_d;
  logic [DATA_W-1:0]  data_d;
  logic               rsp_valid_d, rsp_write_d, rsp_err_d, rsp_timeout_d;
  logic [DATA_W-1:0]  rsp_data_d;

  assign cmd_ready = (state == IDLE) && !rst;
  assign expire    = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(LIMIT));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state decode and next values of every registered output.
  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    awvalid_d     = awvalid;
    wvalid_d      = wvalid;
    arvalid_d     = arvalid;
    bready_d      = bready;
    rready_d      = rready;
    address_d     = address;
    data_d        = data;
    rsp_valid_d   = 1'b0;
    rsp_write_d   = rsp_write;
    rsp_data_d    = rsp_data;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;

    if ((state != IDLE) && (state != RESP) && (TIMEOUT_CYCLES != 0)) cnt_d = cnt + 1'b1;

    unique case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          address_d = cmd_addr;
          data_d    = cmd_wdata;
          cnt_d     = '0;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        // Each write valid retires on its own handshake, in either order.
        awvalid_d = awvalid && !awready;
        wvalid_d  = wvalid && !wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end else if (expire) begin
          awvalid_d     = 1'b0;
          wvalid_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = 1'b1;
          rsp_data_d    = '0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = 1'b1;
          rsp_data_d    = '0;
          rsp_err_d     = sha_error_out;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (expire) begin
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = 1'b1;
          rsp_data_d    = '0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end
      end
      RD_REQ: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end else if (expire) begin
          arvalid_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = 1'b0;
          rsp_data_d    = '0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end
      end
      RD_RESP: begin
        if (rvalid) begin
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = 1'b0;
          rsp_data_d    = data_out;
          rsp_err_d     = sha_error_out;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (expire) begin
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = 1'b0;
          rsp_data_d    = '0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output and counter registers; reset aborts any transaction silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      awvalid     <= 1'b0;
      wvalid      <= 1'b0;
      arvalid     <= 1'b0;
      bready      <= 1'b0;
      rready      <= 1'b0;
      address     <= '0;
      data        <= '0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      cnt         <= cnt_d;
      awvalid     <= awvalid_d;
      wvalid      <= wvalid_d;
      arvalid     <= arvalid_d;
      bready      <= bready_d;
      rready      <= rready_d;
      address     <= address_d;
      data        <= data_d;
      rsp_valid   <= rsp_valid_d;
      rsp_write   <= rsp_write_d;
      rsp_data    <= rsp_data_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_rce_bus_master.sv
// Self-checking bench for rce_bus_master: a table of directed transactions
// with hand-computed response cycles and fields, followed by hand-written
// sequences for reset behaviour and back-to-back commands.
module tb_rce_bus_master;

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 64;
  localparam int unsigned TO  = 8;
  localparam int          WIN = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_write, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] address;
  logic [DW-1:0] data;
  logic          awvalid, wvalid, arvalid, bready, rready;
  logic          awready, wready, arready, bvalid, rvalid;
  logic [DW-1:0] data_out;
  logic          sha_error_out;

  always #5 clk = ~clk;

  rce_bus_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .address(address), .data(data),
    .awvalid(awvalid), .wvalid(wvalid), .arvalid(arvalid),
    .bready(bready), .rready(rready),
    .awready(awready), .wready(wready), .arready(arready),
    .bvalid(bvalid), .rvalid(rvalid),
    .data_out(data_out), .sha_error_out(sha_error_out)
  );

  // a_at: first cycle awready/arready is high; w_at: first cycle wready is high;
  // r_at: first cycle bvalid/rvalid is high. Cycle 1 follows the accept edge.
  typedef struct {
    logic          wr;
    logic [15:0]   addr;
    logic [63:0]   wdata;
    int            a_at;
    int            w_at;
    int            r_at;
    logic [63:0]   rdata;
    logic          err;
    int            exp_cyc;
    logic [63:0]   exp_data;
    logic          exp_err;
    logic          exp_to;
    int            exp_a_last;
    int            exp_w_last;
  } vec_t;

  vec_t vecs[10];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; rvalid = 1'b0;
    data_out = '0; sha_error_out = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          rsp_n, rsp_cyc, a_last, w_last, bad_hold, bad_rdy, wait_n;
    logic [63:0] got_data;
    logic        got_err, got_to, got_wr;
    rsp_n = 0; rsp_cyc = 0; a_last = 0; w_last = 0; bad_hold = 0; bad_rdy = 0; wait_n = 0;
    got_data = '0; got_err = 1'b0; got_to = 1'b0; got_wr = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    while (!cmd_ready && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check($sformatf("v%0d_accept_ready", idx), 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 1; c <= WIN; c++) begin
      if (v.wr) begin
        awready = (c >= v.a_at); wready = (c >= v.w_at); bvalid = (c >= v.r_at);
      end else begin
        arready = (c >= v.a_at); rvalid = (c >= v.r_at);
      end
      data_out = v.rdata; sha_error_out = v.err;
      if (v.wr ? awvalid : arvalid) a_last = c;
      if (wvalid) w_last = c;
      if ((awvalid || wvalid || arvalid) && (address !== v.addr || data !== v.wdata)) bad_hold++;
      if ((bready && (awvalid || wvalid)) || (rready && arvalid) || (bready && rready)) bad_rdy++;
      if (rsp_valid) begin
        rsp_n++;
        if (rsp_n == 1) begin
          rsp_cyc = c; got_data = rsp_data; got_err = rsp_err; got_to = rsp_timeout; got_wr = rsp_write;
        end
      end
      @(negedge clk);
    end
    idle_inputs();
    check($sformatf("v%0d_rsp_count", idx), 64'(rsp_n), 64'd1);
    check($sformatf("v%0d_rsp_cycle", idx), 64'(rsp_cyc), 64'(v.exp_cyc));
    check($sformatf("v%0d_rsp_write", idx), 64'(got_wr), 64'(v.wr));
    check($sformatf("v%0d_rsp_data", idx), got_data, v.exp_data);
    check($sformatf("v%0d_rsp_err", idx), 64'(got_err), 64'(v.exp_err));
    check($sformatf("v%0d_rsp_timeout", idx), 64'(got_to), 64'(v.exp_to));
    check($sformatf("v%0d_req_valid_last", idx), 64'(a_last), 64'(v.exp_a_last));
    check($sformatf("v%0d_wvalid_last", idx), 64'(w_last), 64'(v.exp_w_last));
    check($sformatf("v%0d_hold_violations", idx), 64'(bad_hold), 64'd0);
    check($sformatf("v%0d_ready_violations", idx), 64'(bad_rdy), 64'd0);
    check($sformatf("v%0d_idle_after", idx), 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_rdy, rsp_n, rsp_cyc[2], seen;
    logic        rsp_wr[2];
    logic [63:0] rsp_dat[2];

    vecs[0] = '{wr:1'b1, addr:16'h0010, wdata:64'hDEADBEEF_CAFEF00D, a_at:1, w_at:1, r_at:1,
                rdata:64'h0BAD0BAD_0BAD0BAD, err:1'b0, exp_cyc:3, exp_data:64'h0, exp_err:1'b0,
                exp_to:1'b0, exp_a_last:1, exp_w_last:1};
    vecs[1] = '{wr:1'b1, addr:16'h0044, wdata:64'h11223344_55667788, a_at:1, w_at:4, r_at:1,
                rdata:64'hFFFFFFFF_FFFFFFFF, err:1'b0, exp_cyc:6, exp_data:64'h0, exp_err:1'b0,
                exp_to:1'b0, exp_a_last:1, exp_w_last:4};
    vecs[2] = '{wr:1'b0, addr:16'h0020, wdata:64'h0, a_at:1, w_at:0, r_at:4,
                rdata:64'h01234567_89ABCDEF, err:1'b1, exp_cyc:5, exp_data:64'h01234567_89ABCDEF,
                exp_err:1'b1, exp_to:1'b0, exp_a_last:1, exp_w_last:0};
    vecs[3] = '{wr:1'b0, addr:16'h0030, wdata:64'hCC, a_at:100, w_at:0, r_at:10,
                rdata:64'h77777777_77777777, err:1'b1, exp_cyc:9, exp_data:64'h0, exp_err:1'b0,
                exp_to:1'b1, exp_a_last:8, exp_w_last:0};
    vecs[4] = '{wr:1'b0, addr:16'h0038, wdata:64'h0, a_at:1, w_at:0, r_at:1,
                rdata:64'hA5A5A5A5_5A5A5A5A, err:1'b0, exp_cyc:3, exp_data:64'hA5A5A5A5_5A5A5A5A,
                exp_err:1'b0, exp_to:1'b0, exp_a_last:1, exp_w_last:0};
    vecs[5] = '{wr:1'b1, addr:16'h0050, wdata:64'h0F0F0F0F_0F0F0F0F, a_at:3, w_at:1, r_at:6,
                rdata:64'h0, err:1'b1, exp_cyc:7, exp_data:64'h0, exp_err:1'b1,
                exp_to:1'b0, exp_a_last:3, exp_w_last:1};
    vecs[6] = '{wr:1'b0, addr:16'h0060, wdata:64'h0, a_at:5, w_at:0, r_at:1,
                rdata:64'hFEDCBA98_76543210, err:1'b0, exp_cyc:7, exp_data:64'hFEDCBA98_76543210,
                exp_err:1'b0, exp_to:1'b0, exp_a_last:5, exp_w_last:0};
    vecs[7] = '{wr:1'b1, addr:16'h0070, wdata:64'h00000000_00000007, a_at:2, w_at:3, r_at:8,
                rdata:64'h0, err:1'b1, exp_cyc:9, exp_data:64'h0, exp_err:1'b1,
                exp_to:1'b0, exp_a_last:2, exp_w_last:3};
    vecs[8] = '{wr:1'b0, addr:16'h0080, wdata:64'h0, a_at:1, w_at:0, r_at:9,
                rdata:64'h12345678_12345678, err:1'b1, exp_cyc:9, exp_data:64'h0, exp_err:1'b0,
                exp_to:1'b1, exp_a_last:1, exp_w_last:0};
    vecs[9] = '{wr:1'b1, addr:16'hFFFF, wdata:64'hFFFFFFFF_FFFFFFFF, a_at:1, w_at:100, r_at:1,
                rdata:64'h0, err:1'b1, exp_cyc:9, exp_data:64'h0, exp_err:1'b0,
                exp_to:1'b1, exp_a_last:1, exp_w_last:8};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    check("reset_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
    check("reset_rsp", 64'({rsp_valid, rsp_write, rsp_err, rsp_timeout}), 64'd0);
    check("reset_rsp_data", rsp_data, 64'd0);
    check("reset_address", 64'(address), 64'd0);
    check("reset_data", data, 64'd0);
    rst = 1'b0;
    #1;
    check("release_cmd_ready", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Reset while a write request is outstanding.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0BAD; cmd_wdata = 64'h5A5A_0000_FFFF_1234;
    check("rstmid_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rstmid_awvalid_before", 64'(awvalid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rstmid_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
    check("rstmid_address", 64'(address), 64'd0);
    check("rstmid_data", data, 64'd0);
    check("rstmid_cmd_ready", 64'(cmd_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid_release_ready", 64'(cmd_ready), 64'd1);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("rstmid_no_rsp", 64'(seen), 64'd0);

    // Back-to-back write then read with cmd_valid held high.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0100; cmd_wdata = 64'h1;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; arready = 1'b1; rvalid = 1'b1;
    data_out = 64'h5555AAAA_5555AAAA; sha_error_out = 1'b0;
    check("b2b_first_ready", 64'(cmd_ready), 64'd1);
    first_rdy = 0; rsp_n = 0;
    rsp_cyc[0] = 0; rsp_cyc[1] = 0; rsp_wr[0] = 1'b0; rsp_wr[1] = 1'b1;
    rsp_dat[0] = '1; rsp_dat[1] = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cmd_write = 1'b0; cmd_addr = 16'h0200; cmd_wdata = 64'h2;
      end
      if (first_rdy != 0 && c == first_rdy + 1) cmd_valid = 1'b0;
      if (cmd_ready && first_rdy == 0) first_rdy = c;
      if (rsp_valid) begin
        if (rsp_n < 2) begin
          rsp_cyc[rsp_n] = c; rsp_wr[rsp_n] = rsp_write; rsp_dat[rsp_n] = rsp_data;
        end
        rsp_n++;
      end
    end
    cmd_valid = 1'b0;
    idle_inputs();
    check("b2b_second_accept_cycle", 64'(first_rdy), 64'd4);
    check("b2b_rsp_count", 64'(rsp_n), 64'd2);
    check("b2b_rsp0_cycle", 64'(rsp_cyc[0]), 64'd3);
    check("b2b_rsp0_write", 64'(rsp_wr[0]), 64'd1);
    check("b2b_rsp0_data", rsp_dat[0], 64'd0);
    check("b2b_rsp1_cycle", 64'(rsp_cyc[1]), 64'd7);
    check("b2b_rsp1_write", 64'(rsp_wr[1]), 64'd0);
    check("b2b_rsp1_data", rsp_dat[1], 64'h5555AAAA_5555AAAA);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
